// File: rtl/prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue.
//   INSTR_W       default instruction word width
//   PC_STEP       byte increment between sequential fetches
//   RESET_VECTOR  default first fetch address after reset
//   fetch_state_e fetch FSM encoding (IDLE / REQ / DISCARD)
package prefetch_queue_pkg;

  localparam int          INSTR_W      = 32;
  localparam int          PC_STEP      = 4;
  localparam logic [31:0] RESET_VECTOR = 32'h0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/prefetch_queue_sync_fifo.sv
// Synchronous FIFO holding {pc, instr} entries for the prefetch queue.
// The head entry is read straight from storage, so a word written on one
// edge is visible on rdata the following cycle.
// Ports:
//   clk, rst   clock and synchronous active-high reset (pointers/count only)
//   flush      clears the queue; overrides push and pop in the same cycle
//   push       write wdata at the tail (caller guarantees not full)
//   pop        drop the head entry (caller guarantees not empty)
//   wdata      entry to write
//   rdata      entry at the head
//   count      number of valid entries, 0..DEPTH
module prefetch_queue_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch stage between the memory-side fetch unit and decode.
// Issues sequential fetch requests, queues returned words with their PC and
// presents the queue head to decode over valid/ready. A redirect flushes the
// queue and restarts fetch at the new PC; a request already outstanding when
// the redirect arrives is completed and its data discarded.
// Optional feature macro: PREFETCH_BYPASS_EN -- when defined, a word returning
// to an empty queue is offered to decode combinationally in the ack cycle.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   fetch_en          request to fetch unit, held until fetch_ack
//   fetch_write       always 0 (read-only requester)
//   fetch_addr        request address, stable while fetch_en=1
//   fetch_data        returned word, valid with fetch_ack
//   fetch_ack         one-cycle completion strobe
//   dec_valid         dec_instr/dec_pc valid
//   dec_ready         decode accepts the head word
//   dec_instr, dec_pc head word and its PC
//   redirect_valid    flush queue and restart at redirect_pc
//   redirect_pc       new fetch PC
module prefetch_queue
  import prefetch_queue_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VECTOR)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              fetch_en,
  output logic              fetch_write,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic [DATA_W-1:0] fetch_data,
  input  logic              fetch_ack,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [DATA_W-1:0] dec_instr,
  output logic [ADDR_W-1:0] dec_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int                CNT_W   = $clog2(DEPTH+1);
  localparam int                ENT_W   = ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

  fetch_state_e      state;
  fetch_state_e      state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic              issue;
  logic              push;
  logic              pop;
  logic              bypass_valid;
  logic [CNT_W-1:0]  count;
  logic [ENT_W-1:0]  head;

  // The request is outstanding exactly while the FSM is out of IDLE, so an
  // ack seen in IDLE (including a late one after reset) has no effect.
  assign fetch_en    = (state != IDLE);
  assign fetch_write = 1'b0;

`ifdef PREFETCH_BYPASS_EN
  assign bypass_valid = (state == REQ) && fetch_ack && !redirect_valid && (count == '0);
`else
  assign bypass_valid = 1'b0;
`endif

  always_comb begin
    state_next = state;
    pc_next    = pc;
    issue      = 1'b0;
    push       = 1'b0;
    case (state)
      IDLE: begin
        if (!redirect_valid && (count < DEPTH_C)) begin
          state_next = REQ;
          issue      = 1'b1;
        end
      end
      REQ: begin
        // Every completion returns to IDLE, which yields the one-cycle gap
        // before the next request is reissued.
        if (fetch_ack) begin
          state_next = IDLE;
          if (!redirect_valid) begin
            pc_next = pc + ADDR_W'(PC_STEP);
            push    = !(bypass_valid && dec_ready);
          end
        end else if (redirect_valid) begin
          state_next = DISCARD;
        end
      end
      DISCARD: begin
        if (fetch_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (redirect_valid) pc_next = redirect_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      fetch_addr <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (issue) fetch_addr <= pc;
    end
  end

  assign pop = dec_ready && (count != '0);

  prefetch_queue_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata ({pc, fetch_data}),
    .rdata (head),
    .count (count)
  );

  assign dec_valid = (count != '0) || bypass_valid;
  assign dec_pc    = bypass_valid ? pc         : head[ENT_W-1:DATA_W];
  assign dec_instr = bypass_valid ? fetch_data : head[DATA_W-1:0];

endmodule

// File: tb/tb_prefetch_queue.sv
module tb_prefetch_queue;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic        fetch_write;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_data;
  logic        fetch_ack;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] addr_q[$];
  logic [31:0] decpc_q[$];
  logic [31:0] decin_q[$];
  logic [31:0] held_q[$];

  prefetch_queue #(
    .DEPTH    (4),
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .fetch_write    (fetch_write),
    .fetch_addr     (fetch_addr),
    .fetch_data     (fetch_data),
    .fetch_ack      (fetch_ack),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one cycle before the first post-reset edge (FSM in IDLE).
  task automatic do_reset();
    rst = 1'b1; fetch_ack = 1'b0; fetch_data = '0; dec_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  // Zero-wait fetch model (ack whenever fetch_en, data = addr + 0x100),
  // recording issued addresses and words accepted by decode.
  task automatic auto_cycles(input int n, input logic rdy);
    addr_q.delete(); decpc_q.delete(); decin_q.delete(); held_q.delete();
    for (int i = 0; i < n; i++) begin
      dec_ready = rdy; redirect_valid = 1'b0;
      fetch_ack = fetch_en; fetch_data = fetch_addr + 32'h100;
      #1;
      if (fetch_en && fetch_ack) addr_q.push_back(fetch_addr);
      if (dec_valid && dec_ready) begin
        decpc_q.push_back(dec_pc); decin_q.push_back(dec_instr);
      end
      if (dec_valid && !dec_ready) held_q.push_back(dec_pc);
      cyc();
    end
    fetch_ack = 1'b0; dec_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_ack = 1'b0; fetch_data = '0; dec_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    cyc(); cyc();
    n_checks++; if (fetch_en !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_en: got %b, expected 0", fetch_en); end
    n_checks++; if (fetch_addr !== 32'h0) begin n_fail++; $display("FAIL reset_fetch_addr: got %h, expected 0", fetch_addr); end
    n_checks++; if (fetch_write !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_write: got %b, expected 0", fetch_write); end
    n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dec_valid: got %b, expected 0", dec_valid); end
  endtask

  task automatic test_sequential();
    do_reset();
    auto_cycles(16, 1'b1);
    n_checks++; if (addr_q.size() < 4) begin n_fail++; $display("FAIL seq_req_count: got %0d, expected >=4", addr_q.size()); end
    n_checks++; if (decpc_q.size() < 4) begin n_fail++; $display("FAIL seq_dec_count: got %0d, expected >=4", decpc_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < addr_q.size()) begin
        n_checks++; if (addr_q[i] !== 32'(4*i)) begin n_fail++; $display("FAIL seq_addr[%0d]: got %h, expected %h", i, addr_q[i], 32'(4*i)); end
      end
      if (i < decpc_q.size()) begin
        n_checks++; if (decpc_q[i] !== 32'(4*i)) begin n_fail++; $display("FAIL seq_dec_pc[%0d]: got %h, expected %h", i, decpc_q[i], 32'(4*i)); end
        n_checks++; if (decin_q[i] !== 32'(4*i + 32'h100)) begin n_fail++; $display("FAIL seq_dec_instr[%0d]: got %h, expected %h", i, decin_q[i], 32'(4*i + 32'h100)); end
      end
    end
  endtask

  task automatic test_full_stall();
    do_reset();
    auto_cycles(20, 1'b0);
    n_checks++; if (addr_q.size() !== 4) begin n_fail++; $display("FAIL full_req_count: got %0d, expected 4", addr_q.size()); end
    n_checks++; if (fetch_en !== 1'b0) begin n_fail++; $display("FAIL full_fetch_en: got %b, expected 0", fetch_en); end
    n_checks++; if (held_q.size() < 10) begin n_fail++; $display("FAIL full_held_cycles: got %0d, expected >=10", held_q.size()); end
    foreach (held_q[i]) begin
      n_checks++; if (held_q[i] !== 32'h0) begin n_fail++; $display("FAIL full_hold_pc[%0d]: got %h, expected 0", i, held_q[i]); end
    end
    dec_ready = 1'b1; #1;
    n_checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0 || dec_instr !== 32'h100) begin n_fail++; $display("FAIL full_pop_head: got v=%b pc=%h i=%h, expected v=1 pc=0 i=100", dec_valid, dec_pc, dec_instr); end
    cyc(); dec_ready = 1'b0; #1;
    n_checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h4) begin n_fail++; $display("FAIL full_next_head: got v=%b pc=%h, expected v=1 pc=4", dec_valid, dec_pc); end
    n_checks++; if (fetch_en !== 1'b0) begin n_fail++; $display("FAIL full_gap: got %b, expected 0", fetch_en); end
    cyc();
    n_checks++; if (fetch_en !== 1'b1 || fetch_addr !== 32'h10) begin n_fail++; $display("FAIL full_reissue: got en=%b addr=%h, expected en=1 addr=10", fetch_en, fetch_addr); end
  endtask

  task automatic test_redirect_discard();
    do_reset();
    cyc();
    n_checks++; if (fetch_en !== 1'b1 || fetch_addr !== 32'h0) begin n_fail++; $display("FAIL disc_first_req: got en=%b addr=%h, expected en=1 addr=0", fetch_en, fetch_addr); end
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    cyc(); redirect_valid = 1'b0;
    n_checks++; if (fetch_en !== 1'b1 || fetch_addr !== 32'h0) begin n_fail++; $display("FAIL disc_hold: got en=%b addr=%h, expected en=1 addr=0", fetch_en, fetch_addr); end
    cyc(); cyc();
    fetch_ack = 1'b1; fetch_data = 32'h100; dec_ready = 1'b1; #1;
    n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL disc_late_ack_valid: got %b, expected 0", dec_valid); end
    cyc(); fetch_ack = 1'b0; #1;
    n_checks++; if (dec_valid !== 1'b0 || fetch_en !== 1'b0) begin n_fail++; $display("FAIL disc_after_ack: got v=%b en=%b, expected v=0 en=0", dec_valid, fetch_en); end
    auto_cycles(8, 1'b1);
    n_checks++; if (addr_q.size() < 1 || addr_q[0] !== 32'h40) begin n_fail++; $display("FAIL disc_next_addr: got n=%0d a=%h, expected a=40", addr_q.size(), (addr_q.size() > 0) ? addr_q[0] : 32'hx); end
    n_checks++; if (decpc_q.size() < 1 || decpc_q[0] !== 32'h40 || decin_q[0] !== 32'h140) begin n_fail++; $display("FAIL disc_first_dec: got n=%0d, expected pc=40 instr=140", decpc_q.size()); end
  endtask

  task automatic test_redirect_ack_pop();
    do_reset();
    cyc();
    fetch_ack = 1'b1; fetch_data = 32'h100;
    cyc(); fetch_ack = 1'b0;
    cyc();
    n_checks++; if (fetch_en !== 1'b1 || fetch_addr !== 32'h4) begin n_fail++; $display("FAIL rap_req: got en=%b addr=%h, expected en=1 addr=4", fetch_en, fetch_addr); end
    fetch_ack = 1'b1; fetch_data = 32'h104; redirect_valid = 1'b1; redirect_pc = 32'h80; dec_ready = 1'b1; #1;
    n_checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin n_fail++; $display("FAIL rap_head: got v=%b pc=%h, expected v=1 pc=0", dec_valid, dec_pc); end
    cyc(); fetch_ack = 1'b0; redirect_valid = 1'b0; dec_ready = 1'b0; #1;
    n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL rap_flushed: got %b, expected 0", dec_valid); end
    n_checks++; if (fetch_en !== 1'b0) begin n_fail++; $display("FAIL rap_idle: got %b, expected 0", fetch_en); end
    cyc();
    n_checks++; if (fetch_en !== 1'b1 || fetch_addr !== 32'h80) begin n_fail++; $display("FAIL rap_next_req: got en=%b addr=%h, expected en=1 addr=80", fetch_en, fetch_addr); end
    auto_cycles(6, 1'b1);
    n_checks++; if (decpc_q.size() < 1 || decpc_q[0] !== 32'h80 || decin_q[0] !== 32'h180) begin n_fail++; $display("FAIL rap_first_dec: got n=%0d, expected pc=80 instr=180", decpc_q.size()); end
  endtask

  task automatic test_reset_mid_req();
    do_reset();
    cyc();
    rst = 1'b1;
    cyc();
    fetch_ack = 1'b1; fetch_data = 32'hDEAD; #1;
    n_checks++; if (fetch_en !== 1'b0 || dec_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_reset: got en=%b v=%b, expected 0 0", fetch_en, dec_valid); end
    cyc(); rst = 1'b0; fetch_data = 32'hBEEF; #1;
    n_checks++; if (fetch_en !== 1'b0 || fetch_addr !== 32'h0 || dec_valid !== 1'b0 || fetch_write !== 1'b0) begin n_fail++; $display("FAIL rstmid_outputs: got en=%b addr=%h v=%b w=%b, expected 0 0 0 0", fetch_en, fetch_addr, dec_valid, fetch_write); end
    cyc(); fetch_ack = 1'b0; #1;
    n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_push: got %b, expected 0", dec_valid); end
    n_checks++; if (fetch_en !== 1'b1 || fetch_addr !== 32'h0) begin n_fail++; $display("FAIL rstmid_first_req: got en=%b addr=%h, expected en=1 addr=0", fetch_en, fetch_addr); end
    auto_cycles(4, 1'b1);
    n_checks++; if (decpc_q.size() < 1 || decpc_q[0] !== 32'h0 || decin_q[0] !== 32'h100) begin n_fail++; $display("FAIL rstmid_first_dec: got n=%0d, expected pc=0 instr=100", decpc_q.size()); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc(); redirect_valid = 1'b0;
    auto_cycles(8, 1'b1);
    n_checks++; if (addr_q.size() < 2 || addr_q[0] !== 32'hFFFF_FFFC || addr_q[1] !== 32'h0) begin n_fail++; $display("FAIL wrap_addr: got n=%0d, expected FFFFFFFC then 0", addr_q.size()); end
    n_checks++; if (decpc_q.size() < 2 || decpc_q[1] !== 32'h0 || decin_q[1] !== 32'h100) begin n_fail++; $display("FAIL wrap_dec: got n=%0d, expected pc=0 instr=100", decpc_q.size()); end
  endtask

  task automatic test_bypass();
    do_reset();
    cyc();
    fetch_ack = 1'b1; fetch_data = 32'h100; dec_ready = 1'b1; #1;
`ifdef PREFETCH_BYPASS_EN
    n_checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0 || dec_instr !== 32'h100) begin n_fail++; $display("FAIL byp_ack_cycle: got v=%b pc=%h i=%h, expected v=1 pc=0 i=100", dec_valid, dec_pc, dec_instr); end
    cyc(); fetch_ack = 1'b0; dec_ready = 1'b0; #1;
    n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL byp_not_pushed: got %b, expected 0", dec_valid); end
`else
    n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL byp_ack_cycle: got %b, expected 0", dec_valid); end
    cyc(); fetch_ack = 1'b0; dec_ready = 1'b0; #1;
    n_checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0 || dec_instr !== 32'h100) begin n_fail++; $display("FAIL byp_next_cycle: got v=%b pc=%h i=%h, expected v=1 pc=0 i=100", dec_valid, dec_pc, dec_instr); end
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_full_stall();
    test_redirect_discard();
    test_redirect_ack_pop();
    test_reset_mid_req();
    test_pc_wrap();
    test_bypass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
